// File: rtl/modified_aes_pkg.sv
// Shared primitives for the modified AES-128 encryptor: S-box, Rcon, round transforms, key steps.
// Latency: pure functions, no state.
// Backpressure: none.
`timescale 1ns/1ps
package modified_aes_pkg;

  localparam int NUM_ROUNDS = 10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are packed with row 0 in the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    return o;
  endfunction

  // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = SBOX[s[127-8*n -: 8]];
    return o;
  endfunction

  // Per-byte sum; each byte wraps on its own so no carry leaks into its neighbour.
  function automatic logic [127:0] add_mod256_bytes(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = a[127-8*n -: 8] + b[127-8*n -: 8];
    return o;
  endfunction

  function automatic logic [127:0] key_modify(input logic [127:0] k);
    return {k[63:0], k[127:64]};
  endfunction

  // Standard AES-128 expansion step; always fed the unmodified previous key.
  function automatic logic [127:0] next_round_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/modified_aes_round_stage.sv
// One cipher round: derives Ki/Mi from K(i-1), applies the round, registers si and Ki.
// Latency: 1 cycle.
// Backpressure: none; accepts a new state every cycle.
`timescale 1ns/1ps
module modified_aes_round_stage
  import modified_aes_pkg::*;
#(
  parameter int ROUND   = 1,
  parameter bit IS_LAST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  output logic [127:0] state_out,
  output logic [127:0] key_out
);

  logic [127:0] round_key;
  logic [127:0] mod_key;
  logic [127:0] shifted;
  logic [127:0] mixed;

  assign round_key = next_round_key(key_in, RCON[ROUND-1]);
  assign mod_key   = key_modify(round_key);
  assign shifted   = shift_rows(sub_bytes(state_in));

  if (IS_LAST) begin : g_last
    assign mixed = shifted;
  end else begin : g_mid
    assign mixed = mix_columns(shifted);
  end

  // Register the round result with its unmodified round key so the next stage can expand it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_out <= '0;
      key_out   <= '0;
    end else begin
      state_out <= add_mod256_bytes(mixed, mod_key);
      key_out   <= round_key;
    end
  end

endmodule

// File: rtl/modified_aes128_v1.sv
// Fully pipelined modified AES-128 encryptor (byte-wise mod-256 key add, half-swapped round keys).
// Latency: 10 cycles from datain/key sample to dataout.
// Backpressure: none; one block in and one block out every cycle.
`timescale 1ns/1ps
module modified_aes128_v1
  import modified_aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic [127:0] dataout
);

  logic [127:0] s0;
  logic [NUM_ROUNDS:0][127:0] state_pipe;
  logic [NUM_ROUNDS:0][127:0] key_pipe;
  // The last stage still carries K10 alongside its block; nothing downstream consumes it.
  logic [127:0] final_key_unused;

  // Round 0 is combinational: K0 is added as is, ahead of the first register.
  assign s0            = add_mod256_bytes(datain, key);
  assign state_pipe[0] = s0;
  assign key_pipe[0]   = key;

  for (genvar r = 1; r <= NUM_ROUNDS; r++) begin : g_round
    modified_aes_round_stage #(
      .ROUND   (r),
      .IS_LAST (r == NUM_ROUNDS)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .state_in  (state_pipe[r-1]),
      .key_in    (key_pipe[r-1]),
      .state_out (state_pipe[r]),
      .key_out   (key_pipe[r])
    );
  end

  assign dataout          = state_pipe[NUM_ROUNDS];
  assign final_key_unused = key_pipe[NUM_ROUNDS];

endmodule

// File: tb/tb_modified_aes128_v1.sv
`timescale 1ns/1ps
module tb_modified_aes128_v1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] datain = '0;
  logic [127:0] key = '0;
  logic [127:0] dataout;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb [256];

  typedef struct {
    bit           vld;
    logic [127:0] exp;
  } exp_t;
  exp_t pipe_q[$];

  always #5 clk = ~clk;

  modified_aes128_v1 dut (
    .clk     (clk),
    .rst     (rst),
    .datain  (datain),
    .key     (key),
    .dataout (dataout)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v};
    return d[15-n -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk, res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 16; n++) st[n] = pt[127-8*n -: 8];
    for (int r = 0; r <= 10; r++) begin
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (r > 0) begin
        rk = {rk[63:0], rk[127:64]};
        for (int n = 0; n < 16; n++) st[n] = sb[st[n]];
        for (int c = 0; c < 4; c++)
          for (int rw = 0; rw < 4; rw++)
            tmp[4*c+rw] = st[4*((c+rw)%4)+rw];
        st = tmp;
        if (r < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
            st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
          end
        end
      end
      for (int n = 0; n < 16; n++) st[n] = st[n] + rk[127-8*n -: 8];
    end
    res = '0;
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = st[n];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ne(input string tag, input logic [127:0] obs, input logic [127:0] bad);
    checks++;
    assert (obs !== bad) else begin
      errors++;
      $error("FAIL %s: observed=%h must differ from %h", tag, obs, bad);
    end
  endtask

  // After reset the first 9 outputs are pipeline fill and carry no expectation.
  task automatic clear_model();
    exp_t e;
    e.vld = 1'b0;
    e.exp = '0;
    pipe_q.delete();
    repeat (9) pipe_q.push_back(e);
  endtask

  // One rising edge: record what was sampled, then check what emerges 10 edges after entry.
  task automatic tick(input string tag);
    exp_t e, p;
    @(posedge clk);
    if (!rst) begin
      e.vld = 1'b1;
      e.exp = ref_enc(datain, key);
      pipe_q.push_back(e);
      p = pipe_q.pop_front();
      #1;
      if (p.vld) check(tag, dataout, p.exp);
    end else begin
      #1;
      check({tag, "_in_reset"}, dataout, 128'h0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    build_sbox();

    // Reset acts without a clock edge and holds the output at zero.
    datain = rand128();
    key    = rand128();
    #1 rst = 1'b1;
    #1 check("reset_async", dataout, 128'h0);
    tick("reset_hold");
    datain = rand128();
    key    = rand128();
    tick("reset_hold2");

    // Held inputs: valid from edge 10, then constant.
    rst    = 1'b0;
    clear_model();
    datain = 128'h4142434445464748494a4b4c4d4e4f54;
    key    = 128'h000102030405060708090a0b0c0d0e0f;
    repeat (13) tick("held_vector");

    // FIPS-197 plaintext must not give the standard AES ciphertext.
    datain = 128'h00112233445566778899aabbccddeeff;
    repeat (10) tick("fips_vector");
    check_ne("fips_not_standard_aes", dataout, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Back-to-back random blocks and keys.
    for (int i = 0; i < 30; i++) begin
      datain = rand128();
      key    = rand128();
      tick("random_stream");
    end

    // Reset mid-stream discards everything in flight.
    for (int i = 0; i < 5; i++) begin
      datain = rand128();
      key    = rand128();
      tick("pre_reset_stream");
    end
    rst = 1'b1;
    #1 check("reset_mid_async", dataout, 128'h0);
    tick("reset_mid");
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 15; i++) begin
      datain = rand128();
      key    = rand128();
      tick("post_reset_stream");
    end

    // Byte sums wrap independently in the round-0 adder.
    datain = {16{8'h80}};
    key    = {16{8'h80}};
    #1 check("s0_carry_80", dut.s0, 128'h0);
    datain = {16{8'hff}};
    key    = {16{8'h01}};
    #1 check("s0_carry_ff", dut.s0, 128'h0);
    repeat (10) tick("carry_vector");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
